// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants, types and helpers for the clkdiv_bank divider.
// The optional per-channel gate is enabled with the CLKDIV_GATE_EN macro.
package clkdiv_pkg;

  // Default divisor/counter width.
  localparam int CNT_W_DEF = 32;

  // Divisor value at the default width.
  typedef logic [CNT_W_DEF-1:0] div_t;

  // Width of the channel-select field: clog2(num_ch), never below 1.
  function automatic int ch_sel_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/clkdiv_bank_if.sv
// clkdiv_bank_if: divisor-write / restart control bus and per-channel outputs.
// Signalling: wr_en and restart are single-cycle strobes sampled on the rising
// clock edge; there is no ready/backpressure, a write is always accepted (or
// silently dropped when wr_ch is out of range). div_busy reports that a
// written divisor is still waiting for its channel's next period boundary.
interface clkdiv_bank_if
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
);
  localparam int SEL_W = ch_sel_w(NUM_CH);

  logic              wr_en;
  logic [SEL_W-1:0]  wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic              restart;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] div_busy;

  // Controller side: issues writes/restarts, observes the enables.
  modport master (
    output wr_en, wr_ch, wr_div, restart,
    input  tick, clk_out, div_busy
  );

  // Divider side.
  modport slave (
    input  wr_en, wr_ch, wr_div, restart,
    output tick, clk_out, div_busy
  );
endinterface

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divide-by-N channel. Counts 0..N-1, applies a pending
// divisor only at a period boundary (or at once when stopped/restarted) and
// registers tick/clk_out from next-state so the outputs come straight off flops.
// With CLKDIV_GATE_EN defined, en_i freezes the channel; otherwise en_i is tied high.
module clkdiv_channel #(
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             clk_out_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             started_q, started_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             wrap;

  // Period boundary: last count of a running channel.
  assign wrap = (div_q != '0) && (cnt_q == div_q - CNT_W'(1));

  // Next-state: counter, divisor hand-over, pending capture and output decode.
  always_comb begin
    cnt_d        = cnt_q;
    div_d        = div_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    started_d    = started_q;
    tick_d       = tick_q;
    clk_out_d    = clk_out_q;

    if (!started_q) begin
      // First edge out of reset: count 0 is presented in the following cycle.
      started_d = 1'b1;
      cnt_d     = '0;
    end else if (restart_i) begin
      cnt_d = '0;
      if (pend_valid_q) begin
        div_d        = pend_q;
        pend_valid_d = 1'b0;
      end
    end else if (en_i) begin
      if ((div_q == '0) || wrap) begin
        cnt_d = '0;
        if (pend_valid_q) begin
          div_d        = pend_q;
          pend_valid_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A write always lands in pending; it cannot be consumed on this edge.
    if (wr_i) begin
      pend_d       = wr_div_i;
      pend_valid_d = 1'b1;
    end

    if (started_q && !en_i && !restart_i) begin
      tick_d    = 1'b0;
      clk_out_d = clk_out_q;
    end else begin
      tick_d    = (div_d != '0) && (cnt_d == div_d - CNT_W'(1))
                  && !(started_q && restart_i);
      clk_out_d = (cnt_d < (div_d >> 1));
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      div_q        <= CNT_W'(DEFAULT_DIV);
      pend_q       <= CNT_W'(DEFAULT_DIV);
      pend_valid_q <= 1'b0;
      started_q    <= 1'b0;
      tick_q       <= 1'b0;
      clk_out_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      started_q    <= started_d;
      tick_q       <= tick_d;
      clk_out_q    <= clk_out_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_out_q;
  assign busy_o    = pend_valid_q;

endmodule

// File: rtl/clkdiv_bank.sv
// clkdiv_bank: NUM_CH independent run-time programmable clock-enable dividers.
// The top only decodes wr_ch into per-channel write strobes and fans out restart.
// Define CLKDIV_GATE_EN to add the per-channel ch_en freeze input.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input logic                clk,
  input logic                rst_n,
`ifdef CLKDIV_GATE_EN
  input logic [NUM_CH-1:0]   ch_en,
`endif
  clkdiv_bank_if.slave       bus
);

  localparam int SEL_W = ch_sel_w(NUM_CH);

  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] clk_out_w;
  logic [NUM_CH-1:0] busy_w;

`ifdef CLKDIV_GATE_EN
  assign en = ch_en;
`else
  assign en = '1;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;
    // Out-of-range wr_ch matches no channel, so such writes are dropped.
    assign wr_sel = bus.wr_en && (bus.wr_ch == SEL_W'(i));

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .en_i      (en[i]),
      .restart_i (bus.restart),
      .wr_i      (wr_sel),
      .wr_div_i  (bus.wr_div),
      .tick_o    (tick_w[i]),
      .clk_out_o (clk_out_w[i]),
      .busy_o    (busy_w[i])
    );
  end

  assign bus.tick     = tick_w;
  assign bus.clk_out  = clk_out_w;
  assign bus.div_busy = busy_w;

endmodule

// File: tb/tb_clkdiv_bank.sv
// tb_clkdiv_bank: table vectors, directed corner sequences and randomized
// traffic for clkdiv_bank, checked against an absolute-cycle period model.
module tb_clkdiv_bank;
  import clkdiv_pkg::*;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;
  localparam int DEF    = 4;
  localparam int W      = 3 * NUM_CH;
  localparam int SEL_W  = ch_sel_w(NUM_CH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clkdiv_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus();

`ifdef CLKDIV_GATE_EN
  logic [NUM_CH-1:0] ch_en = '1;
`endif

  clkdiv_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef CLKDIV_GATE_EN
    .ch_en (ch_en),
`endif
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // Model: each channel's current period began at absolute cycle start[c]
  // and has length n[c]; outputs follow from (cyc - start) mod n.
  int cyc;
  int start [NUM_CH];
  int n     [NUM_CH];
  int pend  [NUM_CH];
  bit pv    [NUM_CH];
  bit rflag;
  bit in_rst;

  typedef struct {
    logic              wr_en;
    logic [SEL_W-1:0]  wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic              restart;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] busy;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [NUM_CH-1:0] t, c, b;
    t = '0; c = '0; b = '0;
    if (!in_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        b[i] = pv[i];
        if (n[i] != 0) begin
          int ph;
          ph   = (cyc - start[i]) % n[i];
          t[i] = (ph == n[i] - 1) && !rflag;
          c[i] = (ph < n[i] / 2);
        end
      end
    end
    return {t, c, b};
  endfunction

  task automatic model_init();
    in_rst = 1'b0;
    cyc    = 0;
    rflag  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      start[i] = 0;
      n[i]     = DEF;
      pend[i]  = DEF;
      pv[i]    = 1'b0;
    end
  endtask

  task automatic model_adv(input bit wr, input int ch, input int dv, input bit rs);
    for (int i = 0; i < NUM_CH; i++) begin
      bit boundary;
      boundary = rs || (n[i] == 0) || (((cyc - start[i]) % n[i]) == n[i] - 1);
      if (boundary) begin
        if (pv[i]) begin
          n[i]  = pend[i];
          pv[i] = 1'b0;
        end
        start[i] = cyc + 1;
      end
    end
    if (wr && ch < NUM_CH) begin
      pend[ch] = dv;
      pv[ch]   = 1'b1;
    end
    rflag = rs;
    cyc   = cyc + 1;
  endtask

  task automatic cycle_check();
    logic [W-1:0] got, act;
    exp_q.push_back(model_out());
    act = {bus.tick, bus.clk_out, bus.div_busy};
    got = exp_q.pop_front();
    chk($sformatf("model cyc%0d", cyc), 32'(act), 32'(got));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic wr, input logic [SEL_W-1:0] ch,
                       input logic [CNT_W-1:0] dv, input logic rs);
    bus.wr_en   = wr;
    bus.wr_ch   = ch;
    bus.wr_div  = dv;
    bus.restart = rs;
  endtask

  // Check the current cycle, apply inputs for it, advance one clock.
  task automatic step(input logic wr, input logic [SEL_W-1:0] ch,
                      input logic [CNT_W-1:0] dv, input logic rs);
    cycle_check();
    drive(wr, ch, dv, rs);
    model_adv(wr, int'(ch), int'(dv), rs);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  // Leaves the bench at cycle 0 (first cycle with cnt=0).
  task automatic do_reset();
    rst_n  = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    in_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      cycle_check();
    end
    rst_n = 1'b1;
    cycle_check();
    model_init();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    // {wr_en, wr_ch, wr_div, restart, tick, clk_out, busy}; bits are {ch2,ch1,ch0}
    tbl[0]  = '{1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b111, 3'b000};
    tbl[1]  = '{1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b111, 3'b000};
    tbl[2]  = '{1'b1, 2'd1, 16'd5, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[3]  = '{1'b0, 2'd0, 16'd0, 1'b0, 3'b111, 3'b000, 3'b010};
    tbl[4]  = '{1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b111, 3'b000};
    tbl[5]  = '{1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b111, 3'b000};
    tbl[6]  = '{1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b000, 3'b000};
    tbl[7]  = '{1'b0, 2'd0, 16'd0, 1'b0, 3'b101, 3'b000, 3'b000};
    tbl[8]  = '{1'b0, 2'd0, 16'd0, 1'b0, 3'b010, 3'b101, 3'b000};
    tbl[9]  = '{1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b111, 3'b000};
    tbl[10] = '{1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b010, 3'b000};
    tbl[11] = '{1'b0, 2'd0, 16'd0, 1'b0, 3'b101, 3'b000, 3'b000};
    tbl[12] = '{1'b0, 2'd0, 16'd0, 1'b0, 3'b000, 3'b101, 3'b000};

    drive(1'b0, '0, '0, 1'b0);
    do_reset();

    // Reset release with N=4 everywhere, then N=5 written to ch1 at cycle 2.
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl%0d tick", i), 32'(bus.tick), 32'(tbl[i].tick));
      chk($sformatf("tbl%0d clk_out", i), 32'(bus.clk_out), 32'(tbl[i].clk_out));
      chk($sformatf("tbl%0d busy", i), 32'(bus.div_busy), 32'(tbl[i].busy));
      step(tbl[i].wr_en, tbl[i].wr_ch, tbl[i].wr_div, tbl[i].restart);
    end

    // ch0: N=1 gives a constant tick, then N=0 stops the channel.
    step(1'b1, 2'd0, 16'd1, 1'b0);
    idle(8);
    chk("n1 tick0", 32'(bus.tick[0]), 32'd1);
    chk("n1 clk_out0", 32'(bus.clk_out[0]), 32'd0);
    chk("n1 busy0", 32'(bus.div_busy[0]), 32'd0);
    step(1'b1, 2'd0, 16'd0, 1'b0);
    idle(2);
    chk("n0 tick0", 32'(bus.tick[0]), 32'd0);
    chk("n0 clk_out0", 32'(bus.clk_out[0]), 32'd0);
    idle(3);
    chk("n0 hold tick0", 32'(bus.tick[0]), 32'd0);
    chk("n0 hold clk_out0", 32'(bus.clk_out[0]), 32'd0);

    // N=3 on ch0, N=7 on ch1, restart mid-period, ticks realign 21 cycles on.
    step(1'b1, 2'd0, 16'd3, 1'b0);
    step(1'b1, 2'd1, 16'd7, 1'b0);
    idle(12);
    idle($urandom_range(0, 6));
    step(1'b0, '0, '0, 1'b1);
    chk("restart tick", 32'(bus.tick[1:0]), 32'd0);
    chk("restart clk_out", 32'(bus.clk_out[1:0]), 32'b11);
    idle(20);
    chk("restart coincide", 32'(bus.tick[1:0]), 32'b11);

    // Out-of-range write, then a ch2 write in its wrap cycle.
    step(1'b1, 2'd3, 16'd9, 1'b0);
    chk("illegal busy", 32'(bus.div_busy), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.tick[2]) found = 1'b1;
      else idle(1);
    end
    chk("wait tick2", 32'(found), 32'd1);
    step(1'b1, 2'd2, 16'd6, 1'b0);
    chk("wrapwr busy2 held", 32'(bus.div_busy[2]), 32'd1);
    idle(4);
    chk("wrapwr busy2 clear", 32'(bus.div_busy[2]), 32'd0);
    idle(14);

    // Reset mid-operation discards a pending write.
    step(1'b1, 2'd1, 16'd9, 1'b0);
    do_reset();
    chk("post-reset busy", 32'(bus.div_busy), 32'd0);
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 700; i++) begin
      logic wr, rs;
      logic [SEL_W-1:0] ch;
      logic [CNT_W-1:0] dv;
      wr = ($urandom_range(0, 99) < 25);
      rs = ($urandom_range(0, 99) < 3);
      ch = SEL_W'($urandom_range(0, 3));
      dv = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(10, 40))
                                       : CNT_W'($urandom_range(0, 9));
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(wr, ch, dv, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
